wb_mem_master: RTL

Wishbone classic initiator that turns the core's single-outstanding load/store request into one Wishbone bus cycle. It generates byte selects and lane-replicated write data, and performs lane extraction with sign/zero extension on reads. It sits between the multicycle core's memory stage and the Wishbone interconnect that feeds wb_sram and peripherals.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_lane_align.sv | 22 ++
 rtl/wb_mem_master.sv | 115 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared access-size, FSM-state and byte-select definitions for the Wishbone master.
package wb_pkg;
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_BAD  = 2'b11
    } size_e;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } state_e;
    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return size == SIZE_WORD ? off != 2'b00 : size == SIZE_HALF ? off[0] : size != SIZE_BYTE;
    endfunction
endpackage

// File: rtl/wb_lane_align.sv
// wb_lane_align: byte selects, write-lane replication and read extraction with sign/zero extension.
module wb_lane_align
    import wb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdat,
    output logic [31:0] rext
);
    logic [31:0] shifted;
    always_comb begin
        sel     = size == SIZE_BYTE ? SEL_BYTE << off : size == SIZE_HALF ? SEL_HALF << off : SEL_WORD;
        wdat    = size == SIZE_BYTE ? {4{wdata[7:0]}} : size == SIZE_HALF ? {2{wdata[15:0]}} : wdata;
        shifted = rdata >> {off, 3'b000};
        rext    = size == SIZE_BYTE ? {{24{~uns & shifted[7]}}, shifted[7:0]}
                : size == SIZE_HALF ? {{16{~uns & shifted[15]}}, shifted[15:0]} : shifted;
    end
endmodule

// File: rtl/wb_mem_master.sv
// wb_mem_master: single-outstanding load/store to Wishbone classic initiator.
// Define WB_MASTER_TIMEOUT_EN to add TIMEOUT_CYCLES and a BUS-state watchdog that forces a bus error.
module wb_mem_master
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
`ifdef WB_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           mem_wdata_i,
    output logic [31:0]           mem_rdata_o,
    output logic                  mem_done_o,
    output logic                  mem_err_o,
    output logic                  mem_busy_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic                  wb_we_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i
);
    state_e      state_q, state_d;
    logic [1:0]  size_q, off_q, size_m, off_m;
    logic        uns_q, we_q, bad, timeout, term;
    logic [3:0]  sel_w;
    logic [31:0] wdat_w, rext_w;
    // Before capture the aligner sees the live request, afterwards the captured access.
    assign size_m = state_q == IDLE ? mem_size_i : size_q;
    assign off_m  = state_q == IDLE ? mem_addr_i[1:0] : off_q;
    assign bad    = misaligned(mem_size_i, mem_addr_i[1:0]);
    assign term   = wb_ack_i | wb_err_i | timeout;
    wb_lane_align u_align (
        .size  (size_m),
        .off   (off_m),
        .uns   (uns_q),
        .wdata (mem_wdata_i),
        .rdata (wb_dat_i),
        .sel   (sel_w),
        .wdat  (wdat_w),
        .rext  (rext_w)
    );
`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = TW < 8 ? 8 : TW > 16 ? 16 : TW;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) cnt_q <= '0;
        else            cnt_q <= state_q == BUS ? cnt_q + 1'b1 : '0;
    end
    assign timeout = state_q == BUS && cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= IDLE;
        else            state_q <= state_d;
    end
    always_comb begin
        state_d = state_q == IDLE ? (mem_req_i ? (bad ? RESP : BUS) : IDLE)
                : state_q == BUS  ? (term ? RESP : BUS) : IDLE;
    end
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            size_q      <= '0;
            off_q       <= '0;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            mem_rdata_o <= '0;
            mem_done_o  <= 1'b0;
            mem_err_o   <= 1'b0;
            mem_busy_o  <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_adr_o    <= '0;
            wb_we_o     <= 1'b0;
            wb_sel_o    <= '0;
            wb_dat_o    <= '0;
        end else begin
            mem_done_o <= state_d == RESP;
            mem_busy_o <= state_d != IDLE;
            wb_cyc_o   <= state_d == BUS;
            wb_stb_o   <= state_d == BUS;
            if (state_q == IDLE && mem_req_i) begin
                size_q      <= mem_size_i;
                off_q       <= mem_addr_i[1:0];
                uns_q       <= mem_unsigned_i;
                we_q        <= mem_we_i;
                wb_adr_o    <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                wb_we_o     <= mem_we_i & ~bad;
                wb_sel_o    <= bad ? '0 : sel_w;
                wb_dat_o    <= bad ? '0 : wdat_w;
                mem_err_o   <= bad;
                mem_rdata_o <= '0;
            end else if (state_q == BUS && term) begin
                mem_err_o   <= wb_err_i | timeout;
                mem_rdata_o <= wb_ack_i && !wb_err_i && !timeout && !we_q ? rext_w : '0;
            end else if (state_q == RESP) begin
                mem_err_o   <= 1'b0;
                mem_rdata_o <= '0;
            end
        end
    end
endmodule
